// File: rtl/vic_clken_gen.sv
// vic_clken_gen: fractional-accumulator clock-enable and reset sequencer for the VIC-20 core.
// Generates CPU/VIA phase enables, VIA sub-enables, glitch-free turbo switching and a stretched reset.
module vic_clken_gen #(
    parameter int CLK_HZ       = 25000000,
    parameter int BASE_HZ      = 1000000,
    parameter int SUB_DIV      = 4,
    parameter int MAX_TURBO    = 2,
    parameter int TURBO_W      = 2,
    parameter int RESET_CYCLES = 65535
) (
    input  logic               clk25,
    input  logic               reset_n,
    input  logic [TURBO_W-1:0] turbo,
    input  logic               hold,
    input  logic               btn_reset_n,
    output logic               cpu_clken,
    output logic               cpu_clken_d1,
    output logic               via_clken,
    output logic               sub_clken,
    output logic               sys_reset_n,
    output logic [TURBO_W-1:0] turbo_active
);
    localparam longint INC_BASE = longint'(BASE_HZ) * longint'(SUB_DIV);
    localparam longint INC_MAX  = INC_BASE << MAX_TURBO;
    localparam int     ACC_W    = $clog2(longint'(CLK_HZ) + INC_MAX) + 1;
    localparam int     SUB_W    = (SUB_DIV > 2) ? $clog2(SUB_DIV) : 1;
    localparam int     RST_W    = (RESET_CYCLES > 1) ? $clog2(longint'(RESET_CYCLES) + 1) : 1;

    localparam logic [ACC_W-1:0]   CLK_V    = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0]   INC_V    = ACC_W'(INC_BASE);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RESET_CYCLES);
    localparam logic [TURBO_W-1:0] TURBO_MX = TURBO_W'(MAX_TURBO);

    function automatic logic [TURBO_W-1:0] sat_turbo(input logic [TURBO_W-1:0] t);
        if (int'(t) > MAX_TURBO)
            return TURBO_MX;
        return t;
    endfunction

    logic [ACC_W-1:0] acc;
    logic [SUB_W-1:0] sub_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic             btn_s1, btn_s2;

    logic [ACC_W-1:0] inc_p0;
    logic [ACC_W-1:0] sum_p0;
    logic             sub_tick_p0;
    logic             phase_tick_p0;

    // p0: accumulator step and tick decode for the current cycle
    always_comb begin
        inc_p0        = INC_V << turbo_active;
        sum_p0        = acc + inc_p0;
        sub_tick_p0   = (sum_p0 >= CLK_V);
        phase_tick_p0 = sub_tick_p0 && (sub_cnt == '0);
    end

    // p1: registered enables; turbo only changes on a phase boundary so no phase is ever shortened
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            sub_cnt      <= '0;
            turbo_active <= '0;
            sub_clken    <= 1'b0;
            cpu_clken    <= 1'b0;
            cpu_clken_d1 <= 1'b0;
        end else begin
            acc          <= sub_tick_p0 ? (sum_p0 - CLK_V) : sum_p0;
            sub_clken    <= sub_tick_p0;
            cpu_clken    <= phase_tick_p0 && !hold;
            cpu_clken_d1 <= cpu_clken;
            if (sub_tick_p0)
                sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
            if (phase_tick_p0)
                turbo_active <= sat_turbo(turbo);
        end
    end

    assign via_clken = cpu_clken;

    // Reset stretcher: counts delivered phases, restarts whenever the synchronised button is low
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            rst_cnt     <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            btn_s1 <= btn_reset_n;
            btn_s2 <= btn_s1;
            if (!btn_s2) begin
                rst_cnt     <= '0;
                sys_reset_n <= 1'b0;
            end else begin
                if (phase_tick_p0 && !hold && (rst_cnt < RST_LAST))
                    rst_cnt <= rst_cnt + RST_W'(1);
                sys_reset_n <= (rst_cnt == RST_LAST);
            end
        end
    end
endmodule

// File: tb/tb_vic_clken_gen.sv
// Directed bench for vic_clken_gen: vector table for the post-reset cadence plus
// hand-written sequences for turbo, hold, button reset and mid-run async reset.
module tb_vic_clken_gen;
    localparam int TW   = 2;
    localparam int NREC = 400;
    localparam int NVEC = 15;

    logic          clk25       = 1'b0;
    logic          reset_n     = 1'b0;
    logic [TW-1:0] turbo       = '0;
    logic          hold        = 1'b0;
    logic          btn_reset_n = 1'b1;
    logic          cpu_clken, cpu_clken_d1, via_clken, sub_clken, sys_reset_n;
    logic [TW-1:0] turbo_active;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int   cyc;
        logic cpu;
        logic sub;
        logic d1;
        logic sysr;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [3:0] rec  [1:NREC];

    vic_clken_gen #(.RESET_CYCLES(16)) dut (
        .clk25        (clk25),
        .reset_n      (reset_n),
        .turbo        (turbo),
        .hold         (hold),
        .btn_reset_n  (btn_reset_n),
        .cpu_clken    (cpu_clken),
        .cpu_clken_d1 (cpu_clken_d1),
        .via_clken    (via_clken),
        .sub_clken    (sub_clken),
        .sys_reset_n  (sys_reset_n),
        .turbo_active (turbo_active)
    );

    always #5 clk25 = ~clk25;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge clk25);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        int vi, n, cnt_cpu, cnt_sub, bad, bad2, bad3, last_cpu, prev_cpu;

        vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{6,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{7,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{9,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{13,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{19,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{25,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{26,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{31,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{33,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{38,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{382, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{383, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk25);
        #1;
        check("reset_cpu", cpu_clken, 0);
        check("reset_sub", sub_clken, 0);
        check("reset_sysr", sys_reset_n, 0);
        check("reset_turbo", turbo_active, 0);

        // Post-reset cadence against the vector table, recording the first run
        release_reset();
        vi = 0; cnt_cpu = 0; last_cpu = 0;
        for (int c = 1; c <= NREC; c++) begin
            step();
            rec[c] = {cpu_clken, sub_clken, cpu_clken_d1, sys_reset_n};
            if (cpu_clken) last_cpu = cyc;
            if (cpu_clken && !sys_reset_n) cnt_cpu++;
            if (vi < NVEC && vecs[vi].cyc == c) begin
                check($sformatf("vec%0d_cpu", vi), cpu_clken, vecs[vi].cpu);
                check($sformatf("vec%0d_via", vi), via_clken, vecs[vi].cpu);
                check($sformatf("vec%0d_sub", vi), sub_clken, vecs[vi].sub);
                check($sformatf("vec%0d_d1", vi), cpu_clken_d1, vecs[vi].d1);
                check($sformatf("vec%0d_sysr", vi), sys_reset_n, vecs[vi].sysr);
                vi++;
            end
        end
        check("cpu_before_sysr", cnt_cpu, 16);

        // Turbo 0 rate and spacing over 25000 cycles
        cnt_cpu = 0; cnt_sub = 0; bad = 0; bad2 = 0; bad3 = 0; prev_cpu = 0;
        for (int i = 0; i < 25000; i++) begin
            step();
            if (cpu_clken) begin
                cnt_cpu++;
                if (cyc - last_cpu != 25) bad++;
                last_cpu = cyc;
            end
            if (sub_clken) cnt_sub++;
            if (cpu_clken_d1 !== 1'(prev_cpu)) bad2++;
            if (via_clken !== cpu_clken) bad3++;
            prev_cpu = int'(cpu_clken);
        end
        check("t0_cpu_count", cnt_cpu, 1000);
        check("t0_sub_count", cnt_sub, 4000);
        check("t0_spacing_bad", bad, 0);
        check("t0_d1_lag_bad", bad2, 0);
        check("t0_via_bad", bad3, 0);

        // Hold for 100 cycles
        hold = 1'b1; cnt_cpu = 0; cnt_sub = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cpu_clken) cnt_cpu++;
            if (sub_clken) cnt_sub++;
        end
        hold = 1'b0;
        check("hold_cpu_count", cnt_cpu, 0);
        check("hold_sub_count", cnt_sub, 16);
        n = 0;
        do begin step(); n++; end while (!cpu_clken && n < 60);
        check("hold_resume_seen", cpu_clken, 1);
        check("hold_grid", (cyc - last_cpu) % 25, 0);

        // Button press after release drops sys_reset_n in 3 cycles
        check("btn_pre_sysr", sys_reset_n, 1);
        btn_reset_n = 1'b0; n = 0;
        do begin step(); n++; end while (sys_reset_n && n < 10);
        check("btn_drop_latency", n, 3);
        repeat (2) step();
        btn_reset_n = 1'b1;
        repeat (2) step();
        cnt_cpu = 0; n = 0;
        while (cnt_cpu < 10 && n < 400) begin
            step(); n++;
            if (cpu_clken) cnt_cpu++;
        end
        check("btn_count10_reached", cnt_cpu, 10);
        check("btn_count10_sysr", sys_reset_n, 0);
        // Press mid-count: count must restart from zero
        btn_reset_n = 1'b0;
        repeat (5) step();
        check("btn_mid_sysr", sys_reset_n, 0);
        btn_reset_n = 1'b1;
        repeat (2) step();
        cnt_cpu = 0; n = 0;
        while (n < 600) begin
            step(); n++;
            if (sys_reset_n) break;
            if (cpu_clken) cnt_cpu++;
        end
        check("btn_restart_rise", sys_reset_n, 1);
        check("btn_restart_phases", cnt_cpu, 16);
        check("btn_rise_after_cpu", cpu_clken_d1, 1);

        // Turbo 3 saturates to 2; rate over 25000 cycles
        turbo = 2'd3; n = 0;
        do begin step(); n++; end while (turbo_active == 2'd0 && n < 60);
        check("t2_sat_value", turbo_active, 2);
        check("t2_switch_on_phase", cpu_clken, 1);
        cnt_cpu = 0; cnt_sub = 0; bad = 0; bad2 = 0; prev_cpu = 0;
        for (int i = 0; i < 25000; i++) begin
            step();
            if (cpu_clken) cnt_cpu++;
            if (sub_clken) cnt_sub++;
            if (cpu_clken && prev_cpu != 0) bad++;
            if (turbo_active != 2'd2) bad2++;
            prev_cpu = int'(cpu_clken);
        end
        check("t2_cpu_count", cnt_cpu, 4000);
        check("t2_sub_count", cnt_sub, 16000);
        check("t2_adjacent", bad, 0);
        check("t2_turbo_stable", bad2, 0);

        // Back to turbo 0, then switch 0->1 mid-phase
        turbo = 2'd0; n = 0;
        do begin step(); n++; end while (turbo_active != 2'd0 && n < 60);
        check("t0_back", turbo_active, 0);
        n = 0;
        do begin step(); n++; end while (!cpu_clken && n < 60);
        check("t0_next_phase", cpu_clken, 1);
        repeat (10) step();
        turbo = 2'd1; n = 0;
        do begin step(); n++; end while (turbo_active == 2'd0 && n < 100);
        check("t1_switch_delay", n, 15);
        check("t1_value", turbo_active, 1);
        check("t1_switch_on_phase", cpu_clken, 1);
        cnt_cpu = 0;
        for (int i = 0; i < 12500; i++) begin
            step();
            if (cpu_clken) cnt_cpu++;
        end
        check("t1_cpu_count", cnt_cpu, 1000);

        // Async reset mid-run clears outputs immediately
        reset_n = 1'b0;
        #1;
        check("areset_cpu", cpu_clken, 0);
        check("areset_d1", cpu_clken_d1, 0);
        check("areset_sub", sub_clken, 0);
        check("areset_sysr", sys_reset_n, 0);
        check("areset_turbo", turbo_active, 0);
        turbo = 2'd0;
        repeat (2) @(posedge clk25);
        release_reset();
        bad = 0;
        for (int c = 1; c <= NREC; c++) begin
            step();
            if ({cpu_clken, sub_clken, cpu_clken_d1, sys_reset_n} !== rec[c]) bad++;
        end
        check("rerun_sequence", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
